// File: rtl/rv32i_pkg.sv
// ---------------------------------------------------------------------------
// rv32i_pkg
//   Shared RV32I definitions for the register-file writeback path:
//   - load funct3 encodings (F3_LB..F3_LHU)
//   - wb_entry_t: one pending register-file write {rd, data}
//   - ld_result_t / extract_load(): aligns and sign/zero-extends load data
// ---------------------------------------------------------------------------
package rv32i_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_entry_t;

  typedef struct packed {
    logic            err;
    logic [XLEN-1:0] data;
  } ld_result_t;

  // Picks the addressed byte/half out of the raw word and extends it.
  // Unknown funct3 values yield zero data with err set.
  function automatic ld_result_t extract_load(input logic [2:0]      funct3,
                                              input logic [1:0]      addr_lo,
                                              input logic [XLEN-1:0] rdata);
    ld_result_t res_s;
    logic [7:0]  byte_s;
    logic [15:0] half_s;
    byte_s     = rdata[{addr_lo, 3'b000} +: 8];
    half_s     = rdata[{addr_lo[1], 4'b0000} +: 16];
    res_s.err  = 1'b0;
    res_s.data = {XLEN{1'b0}};
    case (funct3)
      F3_LB:   res_s.data = {{(XLEN-8){byte_s[7]}}, byte_s};
      F3_LH:   res_s.data = {{(XLEN-16){half_s[15]}}, half_s};
      F3_LW:   res_s.data = rdata;
      F3_LBU:  res_s.data = {{(XLEN-8){1'b0}}, byte_s};
      F3_LHU:  res_s.data = {{(XLEN-16){1'b0}}, half_s};
      default: begin
        res_s.err  = 1'b1;
        res_s.data = {XLEN{1'b0}};
      end
    endcase
    return res_s;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// ---------------------------------------------------------------------------
// wb_fifo
//   DEPTH-entry synchronous FIFO of wb_entry_t (DEPTH a power of 2, >= 2).
//   Ports:
//     clk_i, rst_ni   clock, async active-low reset
//     push_i/entry_i  write an entry (ignored when full)
//     pop_i           drop the head entry (ignored when empty)
//     head_o          current head entry
//     full_o/empty_o  status from the registered count
//     count_o         number of stored entries
// ---------------------------------------------------------------------------
module wb_fifo
  import rv32i_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  wb_entry_t                entry_i,
  input  logic                     pop_i,
  output wb_entry_t                head_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  wb_entry_t       mem_r [DEPTH];
  logic [AW-1:0]   wr_ptr_r;
  logic [AW-1:0]   rd_ptr_r;
  logic [AW:0]     count_r;
  logic            push_s;
  logic            pop_s;

  assign full_o  = (count_r == (AW+1)'(DEPTH));
  assign empty_o = (count_r == {(AW+1){1'b0}});
  assign count_o = count_r;
  assign head_o  = mem_r[rd_ptr_r];
  assign push_s  = push_i && !full_o;
  assign pop_s   = pop_i && !empty_o;

  // Storage, pointers (wrap modulo DEPTH) and occupancy count.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '{rd: {REG_AW{1'b0}}, data: {XLEN{1'b0}}};
      end
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= entry_i;
        wr_ptr_r        <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      count_r <= count_r + (AW+1)'(push_s) - (AW+1)'(pop_s);
    end
  end

endmodule

// File: rtl/rf_writeback_ctrl.sv
// ---------------------------------------------------------------------------
// rf_writeback_ctrl
//   Writer side of the RV32I register file. Merges ALU results and load
//   responses onto the single RF write port, buffering ALU results while a
//   load owns the port, and tracks destinations of in-flight loads.
//   Ports:
//     clk_i, rst_ni                       clock, async active-low reset
//     alu_valid_i/alu_ready_o/alu_rd_i/alu_data_i    ALU result handshake
//     ld_issue_valid_i/ld_issue_rd_i      load issued to memory (sets busy)
//     ld_valid_i/ld_ready_o/ld_rd_i/ld_funct3_i/ld_addr_lo_i/ld_rdata_i
//                                         load response handshake
//     wd_address_o/wd_data_o/write_en_rf_o  registered RF write port
//     busy_o                              bit n: load to xn in flight
//     ld_err_o                            pulse: illegal funct3 on a load
// ---------------------------------------------------------------------------
module rf_writeback_ctrl
  import rv32i_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int RD    = 5,
  parameter int DEPTH = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 alu_valid_i,
  output logic                 alu_ready_o,
  input  logic [RD-1:0]        alu_rd_i,
  input  logic [WIDTH-1:0]     alu_data_i,
  input  logic                 ld_issue_valid_i,
  input  logic [RD-1:0]        ld_issue_rd_i,
  input  logic                 ld_valid_i,
  output logic                 ld_ready_o,
  input  logic [RD-1:0]        ld_rd_i,
  input  logic [2:0]           ld_funct3_i,
  input  logic [1:0]           ld_addr_lo_i,
  input  logic [WIDTH-1:0]     ld_rdata_i,
  output logic [RD-1:0]        wd_address_o,
  output logic [WIDTH-1:0]     wd_data_o,
  output logic                 write_en_rf_o,
  output logic [(2**RD)-1:0]   busy_o,
  output logic                 ld_err_o
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int NR = 2**RD;

  logic             ready_r;
  logic [RD-1:0]    addr_r;
  logic [WIDTH-1:0] data_r;
  logic             we_r;
  logic             err_r;
  logic [NR-1:0]    busy_r;

  logic             alu_acc_s;
  logic             ld_acc_s;
  ld_result_t       ld_res_s;
  wb_entry_t        push_entry_s;
  wb_entry_t        fifo_head_s;
  logic             fifo_full_s;
  logic             fifo_empty_s;
  logic [CW-1:0]    fifo_count_s;
  logic [CW-1:0]    cnt_nxt_s;
  logic             push_s;
  logic             pop_s;
  logic             we_nxt_s;
  logic [RD-1:0]    addr_nxt_s;
  logic [WIDTH-1:0] data_nxt_s;
  logic             err_nxt_s;
  logic [NR-1:0]    busy_set_s;
  logic [NR-1:0]    busy_clr_s;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push_s),
    .entry_i (push_entry_s),
    .pop_i   (pop_s),
    .head_o  (fifo_head_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s),
    .count_o (fifo_count_s)
  );

  assign alu_ready_o   = ready_r;
  assign ld_ready_o    = ready_r;
  assign wd_address_o  = addr_r;
  assign wd_data_o     = data_r;
  assign write_en_rf_o = we_r;
  assign ld_err_o      = err_r;
  assign busy_o        = busy_r;

  // Port arbitration: full FIFO drains first, then loads, then buffered ALU
  // results, then a direct ALU bypass. x0 results never enter the FIFO.
  always_comb begin
    alu_acc_s         = alu_valid_i && ready_r;
    ld_acc_s          = ld_valid_i && ready_r;
    ld_res_s          = extract_load(ld_funct3_i, ld_addr_lo_i, ld_rdata_i);
    push_entry_s.rd   = alu_rd_i;
    push_entry_s.data = alu_data_i;
    push_s            = 1'b0;
    pop_s             = 1'b0;
    we_nxt_s          = 1'b0;
    addr_nxt_s        = {RD{1'b0}};
    data_nxt_s        = {WIDTH{1'b0}};
    if (fifo_full_s) begin
      pop_s      = 1'b1;
      we_nxt_s   = 1'b1;
      addr_nxt_s = fifo_head_s.rd;
      data_nxt_s = fifo_head_s.data;
    end else if (ld_acc_s) begin
      we_nxt_s   = (ld_rd_i != {RD{1'b0}});
      addr_nxt_s = ld_rd_i;
      data_nxt_s = ld_res_s.data;
      push_s     = alu_acc_s && (alu_rd_i != {RD{1'b0}});
    end else if (!fifo_empty_s) begin
      pop_s      = 1'b1;
      we_nxt_s   = 1'b1;
      addr_nxt_s = fifo_head_s.rd;
      data_nxt_s = fifo_head_s.data;
      push_s     = alu_acc_s && (alu_rd_i != {RD{1'b0}});
    end else if (alu_acc_s) begin
      we_nxt_s   = (alu_rd_i != {RD{1'b0}});
      addr_nxt_s = alu_rd_i;
      data_nxt_s = alu_data_i;
    end else begin
      we_nxt_s   = 1'b0;
    end
    err_nxt_s = ld_acc_s && ld_res_s.err;
    // Readiness for the next cycle follows the post-update occupancy.
    cnt_nxt_s = fifo_count_s + CW'(push_s) - CW'(pop_s);
  end

  // Busy scoreboard set/clear masks; set is applied after clear so it wins.
  always_comb begin
    busy_set_s = {NR{1'b0}};
    busy_clr_s = {NR{1'b0}};
    if (ld_issue_valid_i && (ld_issue_rd_i != {RD{1'b0}})) begin
      busy_set_s[ld_issue_rd_i] = 1'b1;
    end else begin
      busy_set_s = {NR{1'b0}};
    end
    if (ld_acc_s) begin
      busy_clr_s[ld_rd_i] = 1'b1;
    end else begin
      busy_clr_s = {NR{1'b0}};
    end
  end

  // Registered write port, error pulse, readiness and busy vector.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ready_r <= 1'b0;
      addr_r  <= {RD{1'b0}};
      data_r  <= {WIDTH{1'b0}};
      we_r    <= 1'b0;
      err_r   <= 1'b0;
      busy_r  <= {NR{1'b0}};
    end else begin
      ready_r <= (cnt_nxt_s != CW'(DEPTH));
      addr_r  <= addr_nxt_s;
      data_r  <= data_nxt_s;
      we_r    <= we_nxt_s;
      err_r   <= err_nxt_s;
      busy_r  <= (busy_r & ~busy_clr_s) | busy_set_s;
    end
  end

endmodule
